// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency 256-bit line memory responder (optional checker: PMEM_PROTO_CHK_EN)
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // BUSY spans cycles 1..LATENCY-1 after acceptance, so the counter starts at LATENCY-2
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

  state_t                r_state;
  logic [7:0]            r_cnt;
  logic                  r_is_wr;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [255:0]          r_wdata;
  logic [255:0]          r_rdata;
  logic                  r_resp;
  logic [255:0]          r_mem [0:(1<<DEPTH_LOG2)-1];

  logic w_req;
  logic w_unused_addr;

  assign w_req         = pmem_read | pmem_write;
  assign w_unused_addr = ^{pmem_address[31:DEPTH_LOG2+5], pmem_address[4:0]};

  // Transaction FSM: accept in IDLE, count down in BUSY, pulse response in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_resp <= 1'b0;
          if (w_req) begin
            // write wins when both strobes are high
            r_is_wr <= pmem_write;
            r_idx   <= pmem_address[DEPTH_LOG2+4:5];
            r_wdata <= pmem_wdata;
            r_cnt   <= CNT_LOAD;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt == 8'd0) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
            if (!r_is_wr) begin
              r_rdata <= r_mem[r_idx];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        RESP: begin
          // requests still held here belong to the finished transaction
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Line array: committed at the end of a write's RESP cycle; never cleared by reset
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_is_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign pmem_rdata = r_rdata;
  assign pmem_resp  = r_resp;

`ifdef PMEM_PROTO_CHK_EN
  logic [31:0] r_addr;
  logic        r_proto_err;

  // Full address of the in-flight request, used to spot mid-transaction changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 32'd0;
    end else if (r_state == IDLE && w_req) begin
      r_addr <= pmem_address;
    end
  end

  // Sticky violation flag: dual strobes, dropped request or moved address while BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_proto_err <= 1'b0;
    end else if ((pmem_read && pmem_write) ||
                 (r_state == BUSY && (!w_req || pmem_address != r_addr))) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder
module tb_pmem_responder;

  localparam int LAT = 4;
`ifdef PMEM_PROTO_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         proto_err;

  pmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .proto_err    (proto_err)
  );

  typedef struct {
    int           cyc;
    bit           is_rd;
    logic [255:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model [0:255];
  logic [255:0] last_rd;
  int           cyc;
  int           checks;
  int           failures;
  int           prev_resp;
  int           last_resp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (pmem_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 256'(cyc), 256'(-1));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_cycle", 256'(cyc), 256'(e.cyc));
        if (e.is_rd) check("rdata", pmem_rdata, e.data);
      end
      prev_resp = last_resp;
      last_resp = cyc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one request in an IDLE cycle, optionally dropping/perturbing it after acceptance
  task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [255:0] d, input bit drop_busy);
    exp_t e;
    bit   got;
    logic [7:0] idx;
    idx          = addr[12:5];
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = d;
    e.cyc   = cyc + LAT;
    e.is_rd = rd && !wr;
    e.data  = model[idx];
    if (wr) model[idx] = d;
    else    last_rd = model[idx];
    sb.push_back(e);
    if (drop_busy) begin
      next_cycle();
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = addr ^ 32'h0000_0020;
      pmem_wdata   = ~d;
    end
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pmem_resp) begin
        got = 1'b1;
        break;
      end
    end
    check("resp_seen", 256'(got), 256'(1));
    next_cycle();
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    logic [255:0] pa5;
    logic [255:0] d;
    logic [31:0]  a;
    logic [31:0]  ra [0:5];
    pa5 = {32{8'hA5}};
    checks = 0; failures = 0; cyc = 0; prev_resp = 0; last_resp = 0;
    last_rd = '0;
    for (int i = 0; i < 256; i++) model[i] = 256'(i) ^ {8{32'hC0DE_0000}};
    rst_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0;
    repeat (2) next_cycle();
    check("rst_resp", 256'(pmem_resp), 256'(0));
    check("rst_rdata", pmem_rdata, 256'(0));
    check("rst_proto", 256'(proto_err), 256'(0));
    rst_n = 1'b1;
    next_cycle();

    // preload every line through the DUT so later reads have known contents
    for (int i = 0; i < 256; i++) begin
      pmem_read = 1'b0; pmem_write = 1'b1;
      pmem_address = 32'(i) << 5; pmem_wdata = model[i];
      sb.push_back('{cyc: cyc + LAT, is_rd: 1'b0, data: '0});
      repeat (LAT + 1) next_cycle();
    end
    pmem_write = 1'b0;
    repeat (2) next_cycle();
    check("sb_after_preload", 256'(sb.size()), 256'(0));

    // latency and same-line read with ignored offset bits
    issue(1'b0, 1'b1, 32'h0000_0040, pa5, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_005F, '0, 1'b0);
    check("rd_hold_a5", pmem_rdata, pa5);
    check("proto_clean", 256'(proto_err), 256'(0));

    // back-to-back write then read-fill
    issue(1'b0, 1'b1, 32'h0000_0200, {8{32'h2222_0200}}, 1'b0);
    issue(1'b0, 1'b1, 32'h0000_0100, {8{32'hB0B0_0100}}, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0200, '0, 1'b0);
    check("b2b_gap", 256'(last_resp - prev_resp), 256'(5));
    issue(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0);

    // both strobes: write only, rdata held
    d = pmem_rdata;
    issue(1'b1, 1'b1, 32'h0000_0400, {8{32'hC0C0_0400}}, 1'b0);
    check("rw_rdata_hold", pmem_rdata, d);
    check("rw_proto", 256'(proto_err), 256'(CHK));
    issue(1'b1, 1'b0, 32'h0000_0400, '0, 1'b0);

    // reset in cycle 2 of a write aborts it
    pmem_write = 1'b1; pmem_address = 32'h0000_0040; pmem_wdata = {8{32'hEEEE_EEEE}};
    next_cycle();
    next_cycle();
    rst_n = 1'b0; pmem_write = 1'b0;
    #1;
    check("mid_rst_resp", 256'(pmem_resp), 256'(0));
    check("mid_rst_rdata", pmem_rdata, 256'(0));
    check("mid_rst_proto", 256'(proto_err), 256'(0));
    next_cycle();
    rst_n = 1'b1;
    repeat (LAT + 2) next_cycle();
    check("abort_no_resp", 256'(sb.size()), 256'(0));
    issue(1'b1, 1'b0, 32'h0000_0040, '0, 1'b0);
    check("abort_old_data", pmem_rdata, pa5);

    // request dropped and perturbed during BUSY still completes with latched data
    issue(1'b0, 1'b1, 32'h0000_0600, {8{32'hF00D_0600}}, 1'b1);
    check("drop_proto", 256'(proto_err), 256'(CHK));
    issue(1'b1, 1'b0, 32'h0000_0600, '0, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0620, '0, 1'b0);

    // address aliasing beyond the array
    issue(1'b0, 1'b1, 32'h0000_2000, {8{32'h6060_2000}}, 1'b0);
    issue(1'b1, 1'b0, 32'h0000_0000, '0, 1'b0);
    check("alias_data", pmem_rdata, {8{32'h6060_2000}});

    // random writes followed by read-back
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      ra[i] = a;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      issue(1'b0, 1'b1, a, d, 1'b0);
    end
    for (int i = 0; i < 6; i++) issue(1'b1, 1'b0, ra[i], '0, 1'b0);

    repeat (3) next_cycle();
    check("sb_empty", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to pmem_resp; legal range 2..255.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: log2 of the number of 256-bit lines stored.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port pmem_read, input, 1 bit: line read request, held by the initiator until pmem_resp.
REQ-006 SHALL have port pmem_write, input, 1 bit: line write request, held by the initiator until pmem_resp.
REQ-007 SHALL have port pmem_address, input, 32 bits: byte address of the line.
REQ-008 SHALL have port pmem_wdata, input, 256 bits: write line data.
REQ-009 SHALL have port pmem_rdata, output, 256 bits: read line data.
REQ-010 SHALL have port pmem_resp, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-013 In IDLE with pmem_read or pmem_write high, SHALL accept the request, latch the operation, pmem_address and pmem_wdata, load the latency counter, and enter BUSY.
REQ-014 If pmem_read and pmem_write are both high at acceptance, SHALL perform the write only.
REQ-015 BUSY SHALL decrement the counter every cycle and SHALL enter RESP so that pmem_resp is high exactly LATENCY cycles after the acceptance cycle.
REQ-016 In RESP, pmem_resp SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally, ignoring any request still high during RESP.
REQ-017 A request present in the first IDLE cycle after RESP SHALL be accepted, which supports write-back followed immediately by read-fill.
REQ-018 Line index SHALL be latched address[DEPTH_LOG2+4:5]; bits [4:0] and upper bits SHALL be ignored, so out-of-range addresses alias.
REQ-019 A read SHALL drive pmem_rdata with the indexed line during the RESP cycle.
REQ-020 pmem_rdata SHALL hold that value until the next read completes.
REQ-021 A write SHALL commit the latched data to the array at the end of the RESP cycle.
REQ-022 A read of the same line in the following transaction SHALL return the new data.
REQ-023 If the request is dropped during BUSY, SHALL complete the transaction anyway, committing the write with the latched data and pulsing pmem_resp.
REQ-024 Input changes after acceptance SHALL NOT affect the transaction in flight.

Reset
REQ-025 While rst_n is low, state SHALL be IDLE, counter 0, pmem_resp 0, pmem_rdata 0 and proto_err 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no pmem_resp and no array write.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With macro PMEM_PROTO_CHK_EN defined, proto_err SHALL set and stay set until reset on any of:
- read and write both high in any cycle;
- request dropped while BUSY;
- pmem_address changed while BUSY.
REQ-029 Without PMEM_PROTO_CHK_EN, proto_err SHALL be tied to 0 and no checker logic SHALL be present.
REQ-030 Transaction behaviour SHALL be identical with and without the macro.

Verification
REQ-031 SHALL cover: LATENCY=4; write 0xA5 repeated to 0x0000_0040, accepted at cycle 0 -> pmem_resp high only at cycle 4.
REQ-032 SHALL cover: write 0xA5 repeated to 0x0000_0040, then read of 0x0000_005F (same line) -> pmem_rdata equals the 0xA5 pattern in the RESP cycle.
REQ-033 SHALL cover: write to 0x100 dropped at RESP, pmem_read to 0x200 asserted the next cycle -> read accepted in that cycle; second pmem_resp exactly 5 cycles after the first; line 0x100 holds the write data.
REQ-034 SHALL cover: both read and write high at acceptance -> write committed; pmem_rdata unchanged; proto_err=1 only with PMEM_PROTO_CHK_EN.
REQ-035 SHALL cover: rst_n pulsed low in cycle 2 of a write -> no pmem_resp; a later read of that line returns the old data; all outputs 0 during reset.
REQ-036 SHALL cover: DEPTH_LOG2=8; write to 0x2000 (aliases line 0), then read 0x0 -> the written data is returned.
